// File: rtl/trigger_if.sv
// Trigger unit bus: ADC stream, software arm/configuration and the
// grant/done handshake with the capture stage.
// The trigger block uses the master modport. The slave modport is the
// view from the surrounding system or testbench.
interface trigger_if;
  logic       arm;
  logic       mode;
  logic       trig_edge;
  logic [7:0] threshold;
  logic [2:0] pat_len;
  logic [7:0] pattern;
  logic [7:0] adc_data;
  logic       done;
  logic       grant;
  logic       armed;
  logic       triggered;
  logic       auto_fired;

  modport master (
    input  arm, mode, trig_edge, threshold, pat_len, pattern, adc_data, done,
    output grant, armed, triggered, auto_fired
  );

  modport slave (
    output arm, mode, trig_edge, threshold, pat_len, pattern, adc_data, done,
    input  grant, armed, triggered, auto_fired
  );
endinterface

// File: rtl/trigger.sv
// Trigger unit. It slices the ADC stream against a threshold and starts a
// capture in one of two ways:
//   - an edge crossing (oscilloscope mode)
//   - a serial bit-pattern match (logic-analyser mode)
// It then holds grant until the capture stage reports done.
// Optional feature macro: TRIGGER_AUTO_EN. When it is defined, the unit
// forces a trigger after AUTO_CYCLES armed cycles without a match.
module trigger #(
  parameter int AUTO_CYCLES = 1000000
) (
  input logic      clk,
  input logic      rst,
  trigger_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] hist_q, hist_d;
  logic [3:0] fill_q, fill_d;
  logic       trig_q, trig_d;
  logic       mode_q, mode_d;
  logic       edge_q, edge_d;
  logic [7:0] thr_q, thr_d;
  logic [2:0] len_q, len_d;
  logic [7:0] pat_q, pat_d;

  logic       sampleBit;
  logic [7:0] histNext;
  logic [7:0] patMask;
  logic       edgeMatch;
  logic       patMatch;
  logic       match;

`ifdef TRIGGER_AUTO_EN
  localparam int AUTO_W = $clog2(AUTO_CYCLES + 1);
  logic [AUTO_W-1:0] autoCnt_q, autoCnt_d;
  logic              autoFired_q, autoFired_d;
  logic              autoTimeout;
`else
  logic unused_autoCycles;
  assign unused_autoCycles = (AUTO_CYCLES != 0);
`endif

  // Slice the current sample and evaluate both match conditions against
  // the history as it would look after shifting this sample in.
  always_comb begin
    sampleBit = (bus.adc_data > thr_q);
    histNext  = {hist_q[6:0], sampleBit};
    patMask   = 8'hFF >> (3'd7 - len_q);
    edgeMatch = (fill_q != 4'd0) &&
                (edge_q ? (histNext[1:0] == 2'b01) : (histNext[1:0] == 2'b10));
    patMatch  = (fill_q >= {1'b0, len_q}) &&
                ((histNext & patMask) == (pat_q & patMask));
    match     = mode_q ? patMatch : edgeMatch;
  end

`ifdef TRIGGER_AUTO_EN
  // The timeout fires on the AUTO_CYCLES-th evaluated armed cycle.
  always_comb begin
    autoTimeout = (autoCnt_q == AUTO_W'(AUTO_CYCLES - 1));
  end
`endif

  // Next-state logic: latch the configuration on arm, shift the history
  // while armed, and hold grant until done.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    trig_d  = 1'b0;
    mode_d  = mode_q;
    edge_d  = edge_q;
    thr_d   = thr_q;
    len_d   = len_q;
    pat_d   = pat_q;
`ifdef TRIGGER_AUTO_EN
    autoCnt_d   = autoCnt_q;
    autoFired_d = autoFired_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.arm) begin
          mode_d  = bus.mode;
          edge_d  = bus.trig_edge;
          thr_d   = bus.threshold;
          len_d   = bus.pat_len;
          pat_d   = bus.pattern;
          hist_d  = 8'd0;
          fill_d  = 4'd0;
          state_d = ARMED;
`ifdef TRIGGER_AUTO_EN
          autoCnt_d   = '0;
          autoFired_d = 1'b0;
`endif
        end
      end
      ARMED: begin
        hist_d = histNext;
        fill_d = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
        if (match) begin
          state_d = GRANT;
          trig_d  = 1'b1;
        end
`ifdef TRIGGER_AUTO_EN
        else if (autoTimeout) begin
          state_d     = GRANT;
          trig_d      = 1'b1;
          autoFired_d = 1'b1;
        end else begin
          autoCnt_d = autoCnt_q + AUTO_W'(1);
        end
`endif
      end
      GRANT: begin
        if (bus.done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and shadow registers. The reset is synchronous and overrides any
  // match on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hist_q  <= 8'd0;
      fill_q  <= 4'd0;
      trig_q  <= 1'b0;
      mode_q  <= 1'b0;
      edge_q  <= 1'b0;
      thr_q   <= 8'd0;
      len_q   <= 3'd0;
      pat_q   <= 8'd0;
`ifdef TRIGGER_AUTO_EN
      autoCnt_q   <= '0;
      autoFired_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      trig_q  <= trig_d;
      mode_q  <= mode_d;
      edge_q  <= edge_d;
      thr_q   <= thr_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
`ifdef TRIGGER_AUTO_EN
      autoCnt_q   <= autoCnt_d;
      autoFired_q <= autoFired_d;
`endif
    end
  end

  assign bus.grant     = (state_q == GRANT);
  assign bus.armed     = (state_q == ARMED);
  assign bus.triggered = trig_q;
`ifdef TRIGGER_AUTO_EN
  assign bus.auto_fired = autoFired_q;
`else
  assign bus.auto_fired = 1'b0;
`endif

endmodule
